// File: rtl/dp_pkg.sv
// dp_pkg: shared types and constants for the sequenced datapath.
//
// Contents:
//   alu_op_e  - ALU operation encoding (ADD, SUB, AND, NOT B)
//   shift_e   - shifter control encoding applied to the B operand
//   state_e   - command sequencer states
//   ST_Z/N/V  - bit positions of the flags inside the 3-bit status word
package dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_NOTB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: NREGS x WIDTH register file.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low clear of every entry
//   we         - write enable
//   wr_addr    - write index
//   wr_data    - write data
//   rd_addr_a  - read port A index (combinational)
//   rd_data_a  - read port A data
//   rd_addr_b  - read port B index (combinational)
//   rd_data_b  - read port B data
module dp_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    output logic [WIDTH-1:0]         rd_data_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]         rd_data_b
);

    logic [WIDTH-1:0] regs [NREGS];

    // Single write port; every entry clears on reset so an aborted
    // command can never leave a stale result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Both read ports are combinational so a value written at one edge
    // is visible to the sequencer in the very next cycle.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: self-sequencing datapath (regfile, A/B/C registers,
// shifter, ALU, {V,N,Z} status) driven by a single start pulse.
//
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   start                - command request, accepted only in S_IDLE
//   cmd_rn/rm/rd         - A source, B source, destination registers
//   cmd_aluop, cmd_shift - ALU operation and B-operand shift
//   cmd_asel, cmd_bsel   - zero A operand / use immediate as B operand
//   cmd_imm              - immediate, zero-extended to WIDTH
//   cmd_write, cmd_loads - write result back / update status
//   ext_wr/wrnum/data    - external register write, honoured when idle
//   busy, done           - command in progress / one-cycle completion
//   datapath_out         - C register
//   status_out           - {V,N,Z}
//
// Optional feature: define DATAPATH_SEQ_FAST_EN to skip S_LDA when the
// A operand is forced to zero and S_WB when no writeback is requested.
module datapath_seq
    import dp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(NREGS)-1:0] cmd_rn,
    input  logic [$clog2(NREGS)-1:0] cmd_rm,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [1:0]               cmd_aluop,
    input  logic [1:0]               cmd_shift,
    input  logic                     cmd_asel,
    input  logic                     cmd_bsel,
    input  logic [IMM_W-1:0]         cmd_imm,
    input  logic                     cmd_write,
    input  logic                     cmd_loads,
    input  logic                     ext_wr,
    input  logic [$clog2(NREGS)-1:0] ext_wrnum,
    input  logic [WIDTH-1:0]         ext_data,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         datapath_out,
    output logic [2:0]               status_out
);

    localparam int AW = $clog2(NREGS);

    state_e           state_q, state_d;
    logic [AW-1:0]    lat_rn, lat_rm, lat_rd;
    alu_op_e          lat_aluop;
    shift_e           lat_shift;
    logic             lat_asel, lat_bsel, lat_write, lat_loads;
    logic [IMM_W-1:0] lat_imm;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [2:0]       status_q;
    logic             done_q, done_d;
    logic             accept;

    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata, rf_rd_a, rf_rd_b;

    logic [WIDTH-1:0] b_shifted, ain, bin, alu_res;
    logic             alu_ovf;

    assign accept = (state_q == S_IDLE) && start;

    // The write port is shared: external loads own it while idle, the
    // command's writeback owns it in S_WB; the two never overlap.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ext_wrnum;
        rf_wdata = ext_data;
        if (state_q == S_IDLE && ext_wr) begin
            rf_we = 1'b1;
        end else if (state_q == S_WB && lat_write) begin
            rf_we    = 1'b1;
            rf_waddr = lat_rd;
            rf_wdata = c_q;
        end
    end

    dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .we        (rf_we),
        .wr_addr   (rf_waddr),
        .wr_data   (rf_wdata),
        .rd_addr_a (lat_rn),
        .rd_data_a (rf_rd_a),
        .rd_addr_b (lat_rm),
        .rd_data_b (rf_rd_b)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and completion logic. done is registered, so it is
    // raised in the cycle that follows the last working state, which is
    // also an S_IDLE cycle able to accept the next command.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DATAPATH_SEQ_FAST_EN
                    state_d = cmd_asel ? S_LDB : S_LDA;
`else
                    state_d = S_LDA;
`endif
                end
            end
            S_LDA:  state_d = S_LDB;
            S_LDB:  state_d = S_EXEC;
            S_EXEC: begin
`ifdef DATAPATH_SEQ_FAST_EN
                if (lat_write) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_WB;
`endif
            end
            S_WB: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command fields are captured once on the accepting edge so the
    // decoder is free to change cmd_* while the command runs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_rn    <= '0;
            lat_rm    <= '0;
            lat_rd    <= '0;
            lat_aluop <= ALU_ADD;
            lat_shift <= SH_NONE;
            lat_asel  <= 1'b0;
            lat_bsel  <= 1'b0;
            lat_imm   <= '0;
            lat_write <= 1'b0;
            lat_loads <= 1'b0;
        end else if (accept) begin
            lat_rn    <= cmd_rn;
            lat_rm    <= cmd_rm;
            lat_rd    <= cmd_rd;
            lat_aluop <= alu_op_e'(cmd_aluop);
            lat_shift <= shift_e'(cmd_shift);
            lat_asel  <= cmd_asel;
            lat_bsel  <= cmd_bsel;
            lat_imm   <= cmd_imm;
            lat_write <= cmd_write;
            lat_loads <= cmd_loads;
        end
    end

    // Operand selection and ALU. The immediate bypasses the shifter.
    always_comb begin
        b_shifted = b_q;
        case (lat_shift)
            SH_NONE: b_shifted = b_q;
            SH_LSL1: b_shifted = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_shifted = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
        ain     = lat_asel ? '0 : a_q;
        bin     = lat_bsel ? WIDTH'(lat_imm) : b_shifted;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (lat_aluop)
            ALU_ADD: begin
                alu_res = ain + bin;
                alu_ovf = (ain[WIDTH-1] == bin[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = ain - bin;
                alu_ovf = (ain[WIDTH-1] != bin[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != ain[WIDTH-1]);
            end
            ALU_AND:  alu_res = ain & bin;
            ALU_NOTB: alu_res = ~bin;
        endcase
    end

    // Operand, result and status registers plus the registered done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == S_LDA) begin
                a_q <= rf_rd_a;
            end
            if (state_q == S_LDB) begin
                b_q <= rf_rd_b;
            end
            if (state_q == S_EXEC) begin
                c_q <= alu_res;
                if (lat_loads) begin
                    status_q[ST_Z] <= (alu_res == '0);
                    status_q[ST_N] <= alu_res[WIDTH-1];
                    status_q[ST_V] <= alu_ovf;
                end
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign datapath_out = c_q;
    assign status_out   = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed self-checking bench for datapath_seq.
// Register contents are observed through read-back commands
// (A=0, B=R[x], ADD, no write, no status update).
module tb_datapath_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
    logic [1:0]  cmd_aluop, cmd_shift;
    logic        cmd_asel, cmd_bsel;
    logic [4:0]  cmd_imm;
    logic        cmd_write, cmd_loads;
    logic        ext_wr;
    logic [2:0]  ext_wrnum;
    logic [15:0] ext_data;
    logic        busy, done;
    logic [15:0] datapath_out;
    logic [2:0]  status_out;

    int total = 0;
    int bad   = 0;

`ifdef DATAPATH_SEQ_FAST_EN
    localparam int LAT_NOWR     = 3;
    localparam int LAT_IMM_WR   = 3;
    localparam int LAT_IMM_NOWR = 2;
`else
    localparam int LAT_NOWR     = 4;
    localparam int LAT_IMM_WR   = 4;
    localparam int LAT_IMM_NOWR = 4;
`endif

    datapath_seq #(.WIDTH(16), .NREGS(8), .IMM_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmd_rn       (cmd_rn),
        .cmd_rm       (cmd_rm),
        .cmd_rd       (cmd_rd),
        .cmd_aluop    (cmd_aluop),
        .cmd_shift    (cmd_shift),
        .cmd_asel     (cmd_asel),
        .cmd_bsel     (cmd_bsel),
        .cmd_imm      (cmd_imm),
        .cmd_write    (cmd_write),
        .cmd_loads    (cmd_loads),
        .ext_wr       (ext_wr),
        .ext_wrnum    (ext_wrnum),
        .ext_data     (ext_data),
        .busy         (busy),
        .done         (done),
        .datapath_out (datapath_out),
        .status_out   (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller is positioned at a negedge; start is raised now, the command
    // fields are scrambled right after the accepting edge, and lat counts
    // posedges after that edge until done is seen (-1 on timeout).
    task automatic issue_cmd(input logic [2:0] rn, input logic [2:0] rm,
                             input logic [2:0] rd, input logic [1:0] aluop,
                             input logic [1:0] shift, input logic asel,
                             input logic bsel, input logic [4:0] imm,
                             input logic write, input logic loads,
                             output int lat);
        cmd_rn = rn; cmd_rm = rm; cmd_rd = rd;
        cmd_aluop = aluop; cmd_shift = shift;
        cmd_asel = asel; cmd_bsel = bsel; cmd_imm = imm;
        cmd_write = write; cmd_loads = loads;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ext_wr = 1'b0;
        cmd_rn = ~rn; cmd_rm = ~rm; cmd_rd = ~rd;
        cmd_aluop = ~aluop; cmd_shift = ~shift;
        cmd_asel = ~asel; cmd_bsel = ~bsel; cmd_imm = ~imm;
        cmd_write = ~write; cmd_loads = ~loads;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            lat = -1;
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("[TB] FAIL cmd_timeout: done not seen within 20 cycles");
        end
    endtask

    task automatic run_cmd(input logic [2:0] rn, input logic [2:0] rm,
                           input logic [2:0] rd, input logic [1:0] aluop,
                           input logic [1:0] shift, input logic asel,
                           input logic bsel, input logic [4:0] imm,
                           input logic write, input logic loads,
                           output int lat);
        @(negedge clk);
        issue_cmd(rn, rm, rd, aluop, shift, asel, bsel, imm, write, loads, lat);
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
        int lat;
        run_cmd(3'd0, r, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, lat);
        val = datapath_out;
    endtask

    task automatic ext_write(input logic [2:0] r, input logic [15:0] d);
        @(negedge clk);
        ext_wr = 1'b1; ext_wrnum = r; ext_data = d;
        @(negedge clk);
        ext_wr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_done: got %b want 0", done);
        end
        total++;
        if (datapath_out !== 16'h0000) begin
            bad++; $display("[TB] FAIL reset_out: got %h want 0000", datapath_out);
        end
        total++;
        if (status_out !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_status: got %b want 000", status_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        logic [15:0] v;
        ext_write(3'd0, 16'h0007);
        ext_write(3'd1, 16'h0002);
        run_cmd(3'd0, 3'd1, 3'd2, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, lat);
        total++;
        if (lat != 4) begin
            bad++; $display("[TB] FAIL add_latency: got %0d want 4", lat);
        end
        total++;
        if (datapath_out !== 16'h000B) begin
            bad++; $display("[TB] FAIL add_out: got %h want 000b", datapath_out);
        end
        total++;
        if (status_out !== 3'b000) begin
            bad++; $display("[TB] FAIL add_status: got %b want 000", status_out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("[TB] FAIL add_done_pulse: got %b want 0", done);
        end
        read_reg(3'd2, v);
        total++;
        if (v !== 16'h000B) begin
            bad++; $display("[TB] FAIL add_r2: got %h want 000b", v);
        end
    endtask

    task automatic test_sub_zero;
        int lat;
        run_cmd(3'd0, 3'd0, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, lat);
        total++;
        if (datapath_out !== 16'h0000) begin
            bad++; $display("[TB] FAIL sub_out: got %h want 0000", datapath_out);
        end
        total++;
        if (status_out !== 3'b001) begin
            bad++; $display("[TB] FAIL sub_status: got %b want 001", status_out);
        end
    endtask

    task automatic test_overflow;
        int lat;
        ext_write(3'd3, 16'h7FFF);
        ext_write(3'd4, 16'h0001);
        run_cmd(3'd3, 3'd4, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, lat);
        total++;
        if (datapath_out !== 16'h8000) begin
            bad++; $display("[TB] FAIL ovf_out: got %h want 8000", datapath_out);
        end
        total++;
        if (status_out !== 3'b110) begin
            bad++; $display("[TB] FAIL ovf_status: got %b want 110", status_out);
        end
    endtask

    task automatic test_not_asr;
        int lat;
        ext_write(3'd1, 16'h8004);
        run_cmd(3'd0, 3'd1, 3'd0, 2'b11, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, lat);
        total++;
        if (datapath_out !== 16'h3FFD) begin
            bad++; $display("[TB] FAIL not_asr_out: got %h want 3ffd", datapath_out);
        end
        total++;
        if (status_out !== 3'b110) begin
            bad++; $display("[TB] FAIL not_asr_status_hold: got %b want 110", status_out);
        end
    endtask

    task automatic test_imm;
        int lat;
        logic [15:0] v;
        run_cmd(3'd0, 3'd0, 3'd5, 2'b00, 2'b01, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b0, lat);
        total++;
        if (lat != LAT_IMM_WR) begin
            bad++; $display("[TB] FAIL imm_latency: got %0d want %0d", lat, LAT_IMM_WR);
        end
        read_reg(3'd5, v);
        total++;
        if (v !== 16'h001F) begin
            bad++; $display("[TB] FAIL imm_r5: got %h want 001f", v);
        end
        run_cmd(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b1, 1'b1, 5'h1F, 1'b0, 1'b0, lat);
        total++;
        if (lat != LAT_IMM_NOWR) begin
            bad++; $display("[TB] FAIL imm_nowrite_latency: got %0d want %0d", lat, LAT_IMM_NOWR);
        end
        total++;
        if (datapath_out !== 16'h001F) begin
            bad++; $display("[TB] FAIL imm_nowrite_out: got %h want 001f", datapath_out);
        end
    endtask

    task automatic test_coincident;
        int lat;
        @(negedge clk);
        ext_wr = 1'b1; ext_wrnum = 3'd6; ext_data = 16'h1234;
        issue_cmd(3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, lat);
        total++;
        if (datapath_out !== 16'h1234) begin
            bad++; $display("[TB] FAIL coincident_out: got %h want 1234", datapath_out);
        end
        total++;
        if (status_out !== 3'b000) begin
            bad++; $display("[TB] FAIL coincident_status: got %b want 000", status_out);
        end
    endtask

    task automatic test_busy_start;
        int dones;
        int first;
        logic [15:0] v;
        dones = 0;
        first = -1;
        @(negedge clk);
        cmd_rn = 3'd3; cmd_rm = 3'd4; cmd_rd = 3'd0;
        cmd_aluop = 2'b00; cmd_shift = 2'b00;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = 5'd0;
        cmd_write = 1'b0; cmd_loads = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                start = 1'b1;
                ext_wr = 1'b1; ext_wrnum = 3'd7; ext_data = 16'hFFFF;
                cmd_aluop = 2'b11;
            end else begin
                start = 1'b0;
                ext_wr = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (first < 0) first = k - 1;
            end
        end
        total++;
        if (dones != 1) begin
            bad++; $display("[TB] FAIL busy_done_count: got %0d want 1", dones);
        end
        total++;
        if (first != LAT_NOWR) begin
            bad++; $display("[TB] FAIL busy_latency: got %0d want %0d", first, LAT_NOWR);
        end
        total++;
        if (datapath_out !== 16'h8000) begin
            bad++; $display("[TB] FAIL busy_out: got %h want 8000", datapath_out);
        end
        read_reg(3'd7, v);
        total++;
        if (v !== 16'h0000) begin
            bad++; $display("[TB] FAIL busy_ext_ignored_r7: got %h want 0000", v);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_cmd(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, lat);
        total++;
        if (datapath_out !== 16'h000E) begin
            bad++; $display("[TB] FAIL b2b_first_out: got %h want 000e", datapath_out);
        end
        issue_cmd(3'd0, 3'd4, 3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, lat);
        total++;
        if (lat != LAT_NOWR) begin
            bad++; $display("[TB] FAIL b2b_latency: got %0d want %0d", lat, LAT_NOWR);
        end
        total++;
        if (datapath_out !== 16'h0006) begin
            bad++; $display("[TB] FAIL b2b_second_out: got %h want 0006", datapath_out);
        end
    endtask

    task automatic test_reset_midcmd;
        logic [15:0] v;
        @(negedge clk);
        cmd_rn = 3'd3; cmd_rm = 3'd4; cmd_rd = 3'd6;
        cmd_aluop = 2'b00; cmd_shift = 2'b00;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = 5'd0;
        cmd_write = 1'b1; cmd_loads = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_busy: got %b want 0", busy);
        end
        total++;
        if (datapath_out !== 16'h0000) begin
            bad++; $display("[TB] FAIL midreset_out: got %h want 0000", datapath_out);
        end
        total++;
        if (status_out !== 3'b000) begin
            bad++; $display("[TB] FAIL midreset_status: got %b want 000", status_out);
        end
        @(negedge clk);
        reset = 1'b1;
        read_reg(3'd6, v);
        total++;
        if (v !== 16'h0000) begin
            bad++; $display("[TB] FAIL midreset_r6: got %h want 0000", v);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cmd_rn = '0; cmd_rm = '0; cmd_rd = '0;
        cmd_aluop = '0; cmd_shift = '0;
        cmd_asel = 1'b0; cmd_bsel = 1'b0; cmd_imm = '0;
        cmd_write = 1'b0; cmd_loads = 1'b0;
        ext_wr = 1'b0; ext_wrnum = '0; ext_data = '0;
        test_reset;
        test_add;
        test_sub_zero;
        test_overflow;
        test_not_asr;
        test_imm;
        test_coincident;
        test_busy_start;
        test_back_to_back;
        test_reset_midcmd;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
